// File: rtl/key_gesture_pkg.sv
// Shared types and helpers for the key gesture decoder.
// Event codes and FSM state encodings used by the top and the event slot.
package key_gesture_pkg;

    typedef enum logic [1:0] {
        EVT_REPEAT = 2'd0,
        EVT_SHORT  = 2'd1,
        EVT_DOUBLE = 2'd2,
        EVT_LONG   = 2'd3
    } key_evt_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        HOLD   = 3'd4
    } kg_state_e;

    // Largest of three cycle counts; sizes the single shared timer.
    function automatic int kg_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_evt_slot.sv
// One-entry valid/ready event register; flags a dropped event with a
// single-cycle overflow pulse when a load arrives while the slot is still held.
module key_evt_slot
    import key_gesture_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       load,
    input  logic [1:0] in_code,
    input  logic       ready,
    output logic       valid,
    output logic [1:0] code,
    output logic       ovf
);

    key_evt_e code_q;
    logic     slot_free;

    // An accepting consumer frees the slot in the same cycle a new event lands.
    assign slot_free = !valid || ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid  <= 1'b0;
            code_q <= EVT_REPEAT;
            ovf    <= 1'b0;
        end else begin
            ovf <= load && !slot_free;
            if (load && slot_free) begin
                valid  <= 1'b1;
                code_q <= key_evt_e'(in_code);
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

    assign code = code_q;

endmodule

// File: rtl/key_gesture_decoder.sv
// Classifies debounced key press/release pulses into SHORT, DOUBLE and LONG
// events; optional REPEAT while held is enabled by KEY_GESTURE_REPEAT_EN.
module key_gesture_decoder
    import key_gesture_pkg::*;
#(
    parameter int LONG_CYC   = 25_000_000,
    parameter int DCLK_CYC   = 12_500_000,
    parameter int REPEAT_CYC = 5_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_pos,
    input  logic       i_neg,
    output logic       o_evt_valid,
    output logic [1:0] o_evt_code,
    input  logic       i_evt_ready,
    output logic       o_evt_ovf,
    output logic       o_busy
);

    localparam int CNT_W = $clog2(kg_max3(LONG_CYC, DCLK_CYC, REPEAT_CYC)) + 1;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DCLK_LAST = CNT_W'(DCLK_CYC - 1);
`ifdef KEY_GESTURE_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
`endif
    localparam logic [CNT_W-1:0] TMR_MAX   = '1;

    kg_state_e        state, state_nxt;
    logic [CNT_W-1:0] timer;
    logic             tmr_clr;
    logic             emit;
    key_evt_e         emit_code;
    logic             pos_v, neg_v;

    // Simultaneous press and release cannot come from the debouncer; drop both.
    assign pos_v = i_pos && !i_neg;
    assign neg_v = i_neg && !i_pos;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || tmr_clr) begin
                timer <= '0;
            end else if (timer != TMR_MAX) begin
                timer <= timer + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_clr   = 1'b0;
        emit      = 1'b0;
        emit_code = EVT_SHORT;
        unique case (state)
            IDLE: begin
                if (pos_v) state_nxt = PRESS1;
            end
            PRESS1: begin
                // Release on the LONG threshold cycle counts as a short tap.
                if (neg_v) begin
                    state_nxt = WAIT2;
                end else if (timer == LONG_LAST) begin
                    state_nxt = HOLD;
                    emit      = 1'b1;
                    emit_code = EVT_LONG;
                end
            end
            WAIT2: begin
                if (pos_v) begin
                    state_nxt = PRESS2;
                    emit      = 1'b1;
                    emit_code = EVT_DOUBLE;
                end else if (timer == DCLK_LAST) begin
                    state_nxt = IDLE;
                    emit      = 1'b1;
                    emit_code = EVT_SHORT;
                end
            end
            PRESS2: begin
                if (neg_v) state_nxt = IDLE;
            end
            HOLD: begin
                if (neg_v) begin
                    state_nxt = IDLE;
                end
`ifdef KEY_GESTURE_REPEAT_EN
                else if (timer == REP_LAST) begin
                    tmr_clr   = 1'b1;
                    emit      = 1'b1;
                    emit_code = EVT_REPEAT;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    key_evt_slot u_slot (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .load    (emit),
        .in_code (emit_code),
        .ready   (i_evt_ready),
        .valid   (o_evt_valid),
        .code    (o_evt_code),
        .ovf     (o_evt_ovf)
    );

    assign o_busy = (state != IDLE);

endmodule
